// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop add a + b + cin LSB first,
// one bit per clock, framed by a start/busy/done handshake with a held registered result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, acc_sr;
  logic [WIDTH-1:0] a_shifted, b_shifted, acc_shifted;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_s, carry_next, last_bit;
  logic             busy_next, done_next;

  // The single full-adder cell shared by every bit position.
  assign bit_s      = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit   = (cnt == LAST);

  // Operands shift right; each new sum bit enters at the MSB so bit i settles at i.
  generate
    if (WIDTH == 1) begin : g_one_bit
      assign a_shifted   = '0;
      assign b_shifted   = '0;
      assign acc_shifted = bit_s;
    end else begin : g_multi_bit
      assign a_shifted   = {1'b0, a_sr[WIDTH-1:1]};
      assign b_shifted   = {1'b0, b_sr[WIDTH-1:1]};
      assign acc_shifted = {bit_s, acc_sr[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: a default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state_next)
      RUN:     busy_next = 1'b1;
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            acc_sr <= '0;
            carry  <= cin;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_shifted;
          b_sr   <= b_shifted;
          acc_sr <= acc_shifted;
          carry  <= carry_next;
          cnt    <= cnt + CNT_W'(1);
          // Partial sums stay internal; the port updates only with the final bit.
          if (last_bit) begin
            sum  <= acc_shifted;
            cout <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a WIDTH=1 and a WIDTH=8 instance share clock and reset.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       busy1, done1, cout1;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, cout8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic obs_busy(input bit w1);
    return w1 ? busy1 : busy8;
  endfunction

  function automatic logic obs_done(input bit w1);
    return w1 ? done1 : done8;
  endfunction

  function automatic logic [7:0] obs_sum(input bit w1);
    return w1 ? {7'b0, sum1} : sum8;
  endfunction

  function automatic logic obs_cout(input bit w1);
    return w1 ? cout1 : cout8;
  endfunction

  // Called at a falling edge with the selected DUT idle; returns at a falling edge, idle again.
  task automatic run_op(input bit w1, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input logic [7:0] es, input logic ec, input string tag);
    int         cyc, busy_cnt, lat;
    logic [7:0] held;
    bit         stable, seen;
    lat = w1 ? 1 : 8;
    held = obs_sum(w1);
    if (w1) begin start1 = 1'b1; a1 = av[0]; b1 = bv[0]; cin1 = ci; end
    else    begin start8 = 1'b1; a8 = av;    b8 = bv;    cin8 = ci; end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
    a8 = 8'hC3; b8 = 8'h3C; cin8 = ~cin8;
    cyc = 1; busy_cnt = 0; stable = 1'b1; seen = 1'b0;
    while (cyc <= 30) begin
      if (obs_done(w1)) begin seen = 1'b1; break; end
      if (obs_busy(w1)) busy_cnt++;
      if (obs_sum(w1) !== held) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, seen ? cyc - 1 : 999, lat);
    check({tag, "_busy_cycles"}, busy_cnt, lat);
    check({tag, "_sum_held_in_run"}, {31'b0, stable}, 1);
    check({tag, "_sum"}, obs_sum(w1), es);
    check({tag, "_cout"}, obs_cout(w1), ec);
    check({tag, "_busy_in_done"}, obs_busy(w1), 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, obs_done(w1), 0);
    check({tag, "_sum_hold"}, obs_sum(w1), es);
  endtask

  initial begin
    int         n_done, last_done;
    logic [7:0] exp_hold;
    bit         clean;
    logic       ta, tb, tc;

    #1 rst = 1'b1;
    #1;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_sum1", sum1, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      ta = i[2]; tb = i[1]; tc = i[0];
      run_op(1'b1, {7'b0, ta}, {7'b0, tb}, tc, {7'b0, ta ^ tb ^ tc},
             (ta & tb) | (ta & tc) | (tb & tc), $sformatf("w1_%0d%0d%0d", ta, tb, tc));
    end

    run_op(1'b0, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, "w8_3c_5a");
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "w8_ff_01");
    run_op(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "w8_ff_ff_c1");

    // Start while busy: the second request and the operand garbage are ignored.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    n_done = 0;
    for (int i = 2; i <= 25; i++) begin
      @(negedge clk);
      if (i == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; end
      if (i == 4) begin start8 = 1'b0; a8 = 8'h77; b8 = 8'hEE; end
      if (done8) begin
        n_done++;
        check("busy_start_sum", sum8, 8'h30);
        check("busy_start_cout", cout8, 0);
      end
    end
    check("busy_start_done_count", n_done, 1);

    // Reset in the middle of RUN clears outputs before the next edge.
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy8, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    check("mid_rst_sum", sum8, 0);
    check("mid_rst_cout", cout8, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, "after_rst");

    // Back-to-back with start held high: one result every WIDTH+2 clocks.
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    n_done = 0; last_done = 0; exp_hold = 8'h04; clean = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (done8) begin
        n_done++;
        check($sformatf("b2b_sum_%0d", n_done), sum8, 8'h00);
        check($sformatf("b2b_cout_%0d", n_done), cout8, 1);
        if (n_done > 1) check($sformatf("b2b_gap_%0d", n_done), cyc - last_done, 10);
        last_done = cyc;
        exp_hold = 8'h00;
      end else if (sum8 !== exp_hold) begin
        clean = 1'b0;
      end
    end
    start8 = 1'b0;
    check("b2b_done_count", n_done, 4);
    check("b2b_no_partial_sum", {31'b0, clean}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
